// File: rtl/tdm_pkg.sv
// Shared types for the TDM lane demultiplexer: slot encoding (same as the mux sel) and receiver states.
package tdm_pkg;

   typedef logic [1:0] slot_t;

   localparam slot_t SLOT_A = 2'b00;
   localparam slot_t SLOT_B = 2'b01;
   localparam slot_t SLOT_C = 2'b10;
   localparam slot_t SLOT_D = 2'b11;

   typedef enum logic {HUNT, LOCKED} tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit wrapping slot counter: load jumps to slot 01 (the beat after a frame start), en advances.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load,
   input  logic  en,
   output slot_t sel
);

   slot_t sel_reg;

   always_ff @(posedge clk) begin
      if (reset)
         sel_reg <= SLOT_A;
      else if (load)
         sel_reg <= SLOT_B;
      else if (en)
         sel_reg <= sel_reg + 2'd1;
   end

   assign sel = sel_reg;

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM lane link: frame-aligned demux into lanes a..d with atomic frame update.
// Optional macro TDM_SYNC_ERR_EN adds the sync_err pulse output.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic             frame_valid,
   output logic [1:0]       sel,
   output logic             locked
`ifdef TDM_SYNC_ERR_EN
   ,
   output logic             sync_err
`endif
);

   tdm_state_t       state_reg, state_next;
   logic             ctr_load, ctr_en, frame_done;
   slot_t            slot;
   logic [WIDTH-1:0] stage_reg [0:2];

   tdm_slot_ctr u_ctr (
      .clk   (clk),
      .reset (reset),
      .load  (ctr_load),
      .en    (ctr_en),
      .sel   (slot)
   );

   // A sync anywhere but slot 00 restarts the frame; the counter load doubles as the resync.
   always_comb begin
      state_next = state_reg;
      ctr_load   = 1'b0;
      ctr_en     = 1'b0;
      if (din_valid) begin
         case (state_reg)
            HUNT: begin
               if (sync) begin
                  ctr_load   = 1'b1;
                  state_next = LOCKED;
               end
            end
            LOCKED: begin
               if (sync && slot != SLOT_A)
                  ctr_load = 1'b1;
               else
                  ctr_en = 1'b1;
            end
            default: state_next = HUNT;
         endcase
      end
   end

   assign frame_done = ctr_en && (slot == SLOT_D);

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= HUNT;
      else
         state_reg <= state_next;
   end

   // Slot 11 is never staged: it goes straight to d on the completing edge.
   for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      always_ff @(posedge clk) begin
         if (reset)
            stage_reg[gi] <= '0;
         else if ((ctr_load && gi == 0) || (ctr_en && slot == slot_t'(gi)))
            stage_reg[gi] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a           <= '0;
         b           <= '0;
         c           <= '0;
         d           <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         if (frame_done) begin
            a <= stage_reg[SLOT_A];
            b <= stage_reg[SLOT_B];
            c <= stage_reg[SLOT_C];
            d <= din;
         end
      end
   end

`ifdef TDM_SYNC_ERR_EN
   // Flags a sync off slot 00, and a missing sync where a frame should start.
   always_ff @(posedge clk) begin
      if (reset)
         sync_err <= 1'b0;
      else
         sync_err <= din_valid && (state_reg == LOCKED) &&
                     ((sync && slot != SLOT_A) || (!sync && slot == SLOT_A));
   end
`endif

   assign sel    = slot;
   assign locked = (state_reg == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed cases plus random beats against a frame-queue model.
module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] din = '0;
   logic       din_valid = 1'b0;
   logic       sync = 1'b0;
   logic [3:0] a, b, c, d;
   logic       frame_valid, locked;
   logic [1:0] sel;
`ifdef TDM_SYNC_ERR_EN
   logic       sync_err;
`endif

   always #5 clk = ~clk;

   tdm_demux4 #(.WIDTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .a           (a),
      .b           (b),
      .c           (c),
      .d           (d),
      .frame_valid (frame_valid),
      .sel         (sel),
      .locked      (locked)
`ifdef TDM_SYNC_ERR_EN
      ,
      .sync_err    (sync_err)
`endif
   );

   int errors = 0;
   int checks = 0;
   int fv_count = 0;

   // Model: collected words of the current frame, plus the last published frame.
   bit         m_locked;
   logic [3:0] m_frame [4];
   int         m_cnt;
   logic [3:0] m_out [4];
   logic       m_fv, m_err;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit rst, input bit v, input bit s, input logic [3:0] w);
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (rst) begin
         m_locked = 1'b0;
         m_cnt    = 0;
         for (int i = 0; i < 4; i++) m_out[i] = '0;
      end else if (v) begin
         if (!m_locked) begin
            if (s) begin
               m_locked   = 1'b1;
               m_frame[0] = w;
               m_cnt      = 1;
            end
         end else if (s && m_cnt != 0) begin
            m_err      = 1'b1;
            m_frame[0] = w;
            m_cnt      = 1;
         end else begin
            if (!s && m_cnt == 0) m_err = 1'b1;
            m_frame[m_cnt] = w;
            m_cnt++;
            if (m_cnt == 4) begin
               for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
               m_fv  = 1'b1;
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".a"}, a, m_out[0]);
      chk({tag, ".b"}, b, m_out[1]);
      chk({tag, ".c"}, c, m_out[2]);
      chk({tag, ".d"}, d, m_out[3]);
      chk({tag, ".frame_valid"}, {3'b0, frame_valid}, {3'b0, m_fv});
      chk({tag, ".sel"}, {2'b0, sel}, 4'(m_cnt));
      chk({tag, ".locked"}, {3'b0, locked}, {3'b0, m_locked});
`ifdef TDM_SYNC_ERR_EN
      chk({tag, ".sync_err"}, {3'b0, sync_err}, {3'b0, m_err});
`endif
   endtask

   // One clock: drive on the falling edge, update the model at the rising edge, compare 1 time unit later.
   task automatic cyc(input string tag, input bit rst, input bit v, input bit s, input logic [3:0] w);
      @(negedge clk);
      reset = rst; din_valid = v; sync = s; din = w;
      @(posedge clk);
      model_step(rst, v, s, w);
      #1;
      if (frame_valid) fv_count++;
      check_all(tag);
   endtask

   task automatic beat(input string tag, input bit s, input logic [3:0] w);
      cyc(tag, 1'b0, 1'b1, s, w);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   initial begin
      logic [3:0] fr [4];
      fr[0] = 4'b0000; fr[1] = 4'b1111; fr[2] = 4'b1001; fr[3] = 4'b0110;
      m_locked = 1'b0; m_cnt = 0; m_fv = 1'b0; m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_out[i] = 'x;

      // 1: reset for 2 cycles
      cyc("t1_rst", 1'b1, 1'b0, 1'b0, 4'h0);
      cyc("t1_rst", 1'b1, 1'b0, 1'b0, 4'h0);
      idle("t1_idle", 1);
      chk("t1_a_zero", a, 4'h0);

      // 2: one complete frame
      beat("t2", 1'b1, fr[0]);
      for (int i = 1; i < 4; i++) beat("t2", 1'b0, fr[i]);
      chk("t2_d", d, 4'b0110);
      chk("t2_fv", {3'b0, frame_valid}, 4'h1);
      idle("t2_idle", 1);
      chk("t2_fv_drop", {3'b0, frame_valid}, 4'h0);

      // 3: beats in HUNT without sync are ignored
      cyc("t3_rst", 1'b1, 1'b0, 1'b0, 4'h0);
      beat("t3", 1'b0, 4'b1010);
      beat("t3", 1'b0, 4'b0101);
      chk("t3_locked", {3'b0, locked}, 4'h0);

      // 4: resync mid-frame
      beat("t4", 1'b1, 4'b0000);
      beat("t4", 1'b0, 4'b1111);
      beat("t4_resync", 1'b1, 4'b1001);
      chk("t4_no_fv", {3'b0, frame_valid}, 4'h0);
      beat("t4", 1'b0, 4'b0110);
      beat("t4", 1'b0, 4'b0011);
      beat("t4", 1'b0, 4'b1100);
      chk("t4_a", a, 4'b1001);
      chk("t4_d", d, 4'b1100);

      // 5: frame with 3-cycle gaps, exactly one pulse
      fv_count = 0;
      for (int i = 0; i < 4; i++) begin
         beat("t5", (i == 0), fr[i]);
         idle("t5_gap", 3);
      end
      chk("t5_pulses", 4'(fv_count), 4'd1);
      chk("t5_c", c, 4'b1001);

      // 6: reset after second beat, then a clean frame
      beat("t6", 1'b1, 4'h3);
      beat("t6", 1'b0, 4'h7);
      cyc("t6_rst", 1'b1, 1'b1, 1'b0, 4'h9);
      chk("t6_a_clr", a, 4'h0);
      for (int i = 0; i < 4; i++) beat("t6_frame", (i == 0), fr[i]);
      chk("t6_b", b, 4'b1111);

      // Random: back-to-back frames, gaps, stray syncs, occasional reset
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(99);
         if (r < 2)
            cyc("rnd", 1'b1, 1'b0, 1'b0, 4'h0);
         else
            cyc("rnd", 1'b0, ($urandom_range(9) < 7), ($urandom_range(9) < 2 || m_cnt == 0 && $urandom_range(1) == 1),
                4'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
